unstriping_2lane: RTL



---
 rtl/unstriping_2lane_pkg.sv | 15 +
 rtl/unstriping_2lane_lane_fifo.sv | 67 ++++++
 rtl/unstriping_2lane.sv | 119 +++++++++++
 3 files changed

// File: rtl/unstriping_2lane_pkg.sv
// Shared definitions for the two-lane striper / unstriper pair.
//   DATA_WIDTH_DEF : default lane word width
//   DEPTH_DEF      : default per-lane elastic FIFO depth
//   lane_e         : lane index (LANE0 carries the first word of each pair)
package unstriping_2lane_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF      = 4;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

endpackage

// File: rtl/unstriping_2lane_lane_fifo.sv
// Per-lane synchronous elastic FIFO.
//   clk, rst (async, active-high)
//   wr_en/wr_data : push request; accepted when not full or popped this edge
//   rd_en         : pop request; honoured only when not empty
//   rd_data       : current head (combinational, valid while !empty)
//   full, empty   : status before the edge
//   count         : occupancy 0..DEPTH
module lane_fifo
  import unstriping_2lane_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W:0]        count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q,  count_d;
  logic                  do_wr, do_rd;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_rd    = rd_en && !empty;
    // A full FIFO still accepts a push when its head leaves at the same edge.
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d  = count_q + {{PTR_W{1'b0}}, do_wr} - {{PTR_W{1'b0}}, do_rd};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count says they hold data.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/unstriping_2lane.sv
// Two-lane unstriper: rebuilds a single word stream from lane_0/lane_1,
// strictly alternating lane 0, lane 1, lane 0, ...
//   clk_2f            : word-rate clock
//   reset             : async, active-high; clears all state
//   lane_k / valid_k  : incoming lane words, buffered in an elastic FIFO each
//   data_out/valid_out: registered recombined word (data_out=0 when invalid)
//   overflow_0/1      : sticky, set when a lane word was dropped on a full FIFO
//   lane_sel          : lane the next output word will be taken from
module unstriping_2lane
  import unstriping_2lane_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned PTR_W      = 2
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] lane_0,
  input  logic                  valid_0,
  input  logic [DATA_WIDTH-1:0] lane_1,
  input  logic                  valid_1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  overflow_0,
  output logic                  overflow_1,
  output logic                  lane_sel
);

  lane_e                 lane_sel_q,   lane_sel_d;
  logic [DATA_WIDTH-1:0] data_out_q,   data_out_d;
  logic                  valid_out_q,  valid_out_d;
  logic                  overflow_0_q, overflow_0_d;
  logic                  overflow_1_q, overflow_1_d;

  logic [DATA_WIDTH-1:0] head_0, head_1;
  logic                  full_0, full_1, empty_0, empty_1;
  logic [PTR_W:0]        count_0, count_1;
  logic                  pop_0, pop_1;

  // Never skip a lane: only the selected FIFO may be popped.
  assign pop_0 = (lane_sel_q == LANE0) && !empty_0;
  assign pop_1 = (lane_sel_q == LANE1) && !empty_1;

  lane_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_fifo_0 (
    .clk     (clk_2f),
    .rst     (reset),
    .wr_en   (valid_0),
    .wr_data (lane_0),
    .rd_en   (pop_0),
    .rd_data (head_0),
    .full    (full_0),
    .empty   (empty_0),
    .count   (count_0)
  );

  lane_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_fifo_1 (
    .clk     (clk_2f),
    .rst     (reset),
    .wr_en   (valid_1),
    .wr_data (lane_1),
    .rd_en   (pop_1),
    .rd_data (head_1),
    .full    (full_1),
    .empty   (empty_1),
    .count   (count_1)
  );

  // Occupancy is exported by the FIFO for observation only.
  logic unused_counts;
  assign unused_counts = ^{count_0, count_1};

  always_comb begin
    lane_sel_d   = lane_sel_q;
    data_out_d   = '0;
    valid_out_d  = 1'b0;
    overflow_0_d = overflow_0_q | (valid_0 && full_0 && !pop_0);
    overflow_1_d = overflow_1_q | (valid_1 && full_1 && !pop_1);
    if (pop_0) begin
      data_out_d  = head_0;
      valid_out_d = 1'b1;
      lane_sel_d  = LANE1;
    end else if (pop_1) begin
      data_out_d  = head_1;
      valid_out_d = 1'b1;
      lane_sel_d  = LANE0;
    end
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      lane_sel_q   <= LANE0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      overflow_0_q <= 1'b0;
      overflow_1_q <= 1'b0;
    end else begin
      lane_sel_q   <= lane_sel_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      overflow_0_q <= overflow_0_d;
      overflow_1_q <= overflow_1_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign overflow_0 = overflow_0_q;
  assign overflow_1 = overflow_1_q;
  assign lane_sel   = lane_sel_q;

endmodule
